// File: rtl/switch_pkg.sv
// Shared types for the switch conditioning block: default width, switch vector
// type and the per-bit debounce filter state encoding.
package switch_pkg;
  localparam int SWITCH_WIDTH = 4;

  typedef logic [SWITCH_WIDTH-1:0] switch_t;

  // bit[1] = accepted output level, bit[0] = a disagreeing run is in progress
  typedef enum logic [1:0] {
    STABLE_LOW  = 2'b00,
    PEND_HIGH   = 2'b01,
    STABLE_HIGH = 2'b10,
    PEND_LOW    = 2'b11
  } filt_state_e;
endpackage

// File: rtl/debounce_bit.sv
// One switch bit's debounce filter: accepts a new level after STABLE_CYCLES
// consecutive disagreeing samples and emits registered rise/fall strobes.
module debounce_bit
  import switch_pkg::*;
#(
  parameter int   STABLE_CYCLES = 16,
  parameter logic RESET_BIT     = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic sync_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o,
  output logic flip_o
);
  localparam int             CW        = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0]  LAST      = CW'(STABLE_CYCLES - 1);
  localparam filt_state_e    RST_STATE = RESET_BIT ? STABLE_HIGH : STABLE_LOW;

  filt_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rise_q, rise_d, fall_q, fall_d;
  logic          level;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= RST_STATE;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level = state_q[1];

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (sync_i == level) begin
      // any agreeing sample drops a pending run
      state_d = level ? STABLE_HIGH : STABLE_LOW;
    end else if (cnt_q == LAST) begin
      state_d = sync_i ? STABLE_HIGH : STABLE_LOW;
      rise_d  = sync_i;
      fall_d  = ~sync_i;
    end else begin
      cnt_d   = cnt_q + 1'b1;
      state_d = level ? PEND_LOW : PEND_HIGH;
    end
  end

  assign level_o = level;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;
  assign flip_o  = rise_d | fall_d;
endmodule

// File: rtl/switch_debouncer.sv
// Switch pin conditioner: shared 2-FF synchroniser, WIDTH independent debounce
// filters and a registered any-edge indicator aligned with the strobes.
module switch_debouncer
  import switch_pkg::*;
#(
  parameter int               WIDTH         = SWITCH_WIDTH,
  parameter int               STABLE_CYCLES = 16,
  parameter logic [WIDTH-1:0] RESET_LEVEL   = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] switch_in,
  output logic [WIDTH-1:0] switch_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic             changed
);
  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] pulse_d;
  logic             changed_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q   <= RESET_LEVEL;
      sync2_q   <= RESET_LEVEL;
      changed_q <= 1'b0;
    end else begin
      sync1_q   <= switch_in;
      sync2_q   <= sync1_q;
      changed_q <= |pulse_d;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .RESET_BIT     (RESET_LEVEL[i])
    ) u_bit (
      .clock   (clock),
      .reset   (reset),
      .sync_i  (sync2_q[i]),
      .level_o (switch_out[i]),
      .rise_o  (rise_pulse[i]),
      .fall_o  (fall_pulse[i]),
      .flip_o  (pulse_d[i])
    );
  end

  assign changed = changed_q;
endmodule
